// File: rtl/oqpsk_pkg.sv
// oqpsk_pkg: shared types, defaults and half-sine table builder for the O-QPSK modulator.
package oqpsk_pkg;
    localparam int DEF_CLK_PER_SAMPLE = 5;
    localparam int DEF_SPC            = 5;
    localparam int DEF_W              = 5;
    localparam int PH_W               = 4;  // phase field covers SPC up to 8

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef struct packed {
        logic            active;
        logic            sign;
        logic [PH_W-1:0] phase;
    } rail_t;

    // round((2^(w-1)-1) * sin(pi*(k+0.5)/(2*spc))) in 2^28 fixed point, Taylor series to x^11
    function automatic int half_sine(int k, int spc, int w);
        longint s, x, term, sum, amp, kk, sp;
        s = 64'sd1 <<< 28;
        sp = longint'(spc);
        kk = (k < spc) ? longint'(k) : 2 * sp - 1 - longint'(k);
        x = (64'sd843314857 * (2 * kk + 1)) / (4 * sp);
        term = x;
        sum = x;
        for (longint n = 1; n <= 5; n++) begin
            term = -((term * x / s) * x / s) / (2 * n * (2 * n + 1));
            sum = sum + term;
        end
        amp = (64'sd1 <<< (w - 1)) - 1;
        return int'((amp * sum + s / 2) / s);
    endfunction

    function automatic rail_t rail_step(rail_t r, logic [PH_W-1:0] last);
        rail_t n;
        n = r;
        if (r.active) begin
            n.phase = r.phase + 1'b1;
            n.active = (r.phase != last);
        end
        return n;
    endfunction
endpackage

// File: rtl/half_sine_rom.sv
// half_sine_rom: phase -> half-sine pulse magnitude lookup for one rail.
module half_sine_rom
    import oqpsk_pkg::*;
#(
    parameter int SPC = DEF_SPC,
    parameter int W   = DEF_W
) (
    input  logic [PH_W-1:0] i_phase,
    output logic [W-1:0]    o_mag
);
    logic [W-1:0] w_lut [2*SPC];

    for (genvar k = 0; k < 2 * SPC; k++) begin : g_lut
        localparam int MAG = half_sine(k, SPC, W);
        assign w_lut[k] = W'(MAG);
    end

    assign o_mag = (i_phase < PH_W'(2 * SPC)) ? w_lut[i_phase] : '0;
endmodule

// File: rtl/oqpsk_modulator.sv
// oqpsk_modulator: 802.15.4 chip stream to half-sine shaped O-QPSK I/Q samples.
module oqpsk_modulator
    import oqpsk_pkg::*;
#(
    parameter int CLK_PER_SAMPLE = DEF_CLK_PER_SAMPLE,
    parameter int SPC            = DEF_SPC,
    parameter int W              = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         chip_in,
    input  logic         chip_last,
    input  logic         chip_valid,
    output logic         chip_ready,
    output logic [W-1:0] i_out,
    output logic [W-1:0] q_out,
    output logic         sample_valid,
    output logic         busy,
    output logic         underrun
);
    localparam int DIV_W = $clog2(CLK_PER_SAMPLE + 1);
    localparam int SIDX_W = $clog2(SPC + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SPC - 1);

    state_t            r_state, w_state_nxt;
    logic              r_buf_full, r_buf_chip, r_buf_last;
    logic [DIV_W-1:0]  r_div;
    logic [SIDX_W-1:0] r_sidx;
    logic              r_parity;  // 0: next chip goes to I, 1: to Q
    rail_t             r_i, r_q, w_i_nxt, w_q_nxt, w_new;
    logic              w_tick, w_bound, w_pop, w_load, w_parity_nxt, w_underrun_nxt;
    logic [W-1:0]      w_i_mag, w_q_mag, w_i_smp, w_q_smp, r_i_out, r_q_out;
    logic              r_sample_valid, r_underrun;

    half_sine_rom #(.SPC(SPC), .W(W)) u_i_rom (.i_phase(r_i.phase), .o_mag(w_i_mag));
    half_sine_rom #(.SPC(SPC), .W(W)) u_q_rom (.i_phase(r_q.phase), .o_mag(w_q_mag));

    assign w_tick = (r_state != IDLE) && (r_div == DIV_W'(CLK_PER_SAMPLE - 1));
    assign w_bound = w_tick && (r_sidx == SIDX_W'(SPC - 1));
    assign w_load = chip_valid && !r_buf_full;
    assign w_new = '{active: 1'b1, sign: r_buf_chip, phase: '0};
    assign w_i_smp = !r_i.active ? '0 : r_i.sign ? w_i_mag : -w_i_mag;
    assign w_q_smp = !r_q.active ? '0 : r_q.sign ? w_q_mag : -w_q_mag;

    assign chip_ready = !r_buf_full;
    assign busy = (r_state != IDLE);
    assign i_out = r_i_out;
    assign q_out = r_q_out;
    assign sample_valid = r_sample_valid;
    assign underrun = r_underrun;

    always_comb begin
        w_state_nxt = r_state;
        w_pop = 1'b0;
        w_underrun_nxt = 1'b0;
        w_parity_nxt = r_parity;
        w_i_nxt = w_tick ? rail_step(r_i, PH_LAST) : r_i;
        w_q_nxt = w_tick ? rail_step(r_q, PH_LAST) : r_q;
        case (r_state)
            IDLE: if (r_buf_full) begin
                w_pop = 1'b1;
                w_i_nxt = w_new;
                w_parity_nxt = 1'b1;
                w_state_nxt = r_buf_last ? FLUSH : RUN;
            end
            RUN: if (w_bound) begin
                w_pop = r_buf_full;
                w_underrun_nxt = !r_buf_full;
                w_state_nxt = (!r_buf_full || r_buf_last) ? FLUSH : RUN;
                if (r_buf_full) begin
                    w_parity_nxt = !r_parity;
                    if (r_parity) w_q_nxt = w_new;
                    else w_i_nxt = w_new;
                end
            end
            FLUSH: if (w_tick && (!r_i.active || r_i.phase == PH_LAST)
                              && (!r_q.active || r_q.phase == PH_LAST)) begin
                w_state_nxt = IDLE;
                w_parity_nxt = 1'b0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_full <= 1'b0;
            r_buf_chip <= 1'b0;
            r_buf_last <= 1'b0;
            r_div <= '0;
            r_sidx <= '0;
            r_parity <= 1'b0;
            r_i <= '0;
            r_q <= '0;
            r_i_out <= '0;
            r_q_out <= '0;
            r_sample_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_buf_full <= w_pop ? 1'b0 : (w_load || r_buf_full);
            if (w_load) begin
                r_buf_chip <= chip_in;
                r_buf_last <= chip_last;
            end
            r_div <= (r_state == IDLE || w_tick) ? '0 : r_div + 1'b1;
            r_sidx <= (r_state == IDLE || w_bound) ? '0 : w_tick ? r_sidx + 1'b1 : r_sidx;
            r_parity <= w_parity_nxt;
            r_i <= w_i_nxt;
            r_q <= w_q_nxt;
            r_i_out <= w_tick ? w_i_smp : (r_state == IDLE) ? '0 : r_i_out;
            r_q_out <= w_tick ? w_q_smp : (r_state == IDLE) ? '0 : r_q_out;
            r_sample_valid <= w_tick;
            r_underrun <= w_underrun_nxt;
        end
    end
endmodule

// File: tb/tb_oqpsk_modulator.sv
// tb_oqpsk_modulator: directed self-checking bench for the O-QPSK modulator.
module tb_oqpsk_modulator;
    logic       clk = 1'b0, reset = 1'b1, chip_in = 1'b0, chip_last = 1'b0, chip_valid = 1'b0;
    logic       chip_ready, sample_valid, busy, underrun;
    logic [4:0] i_out, q_out;
    int n_vec = 0, n_err = 0, cyc = 0;
    int lut [10] = '{2, 7, 11, 13, 15, 15, 13, 11, 7, 2};
    int si[$], sq[$], sc[$], xc[$], uc[$];

    oqpsk_modulator dut (
        .clk(clk), .reset(reset), .chip_in(chip_in), .chip_last(chip_last),
        .chip_valid(chip_valid), .chip_ready(chip_ready), .i_out(i_out), .q_out(q_out),
        .sample_valid(sample_valid), .busy(busy), .underrun(underrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (chip_valid && chip_ready) xc.push_back(cyc);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (sample_valid) begin
            si.push_back(int'($signed(i_out)));
            sq.push_back(int'($signed(q_out)));
            sc.push_back(cyc);
        end
        if (underrun) uc.push_back(cyc);
    end

    task automatic clear_logs();
        si.delete(); sq.delete(); sc.delete(); xc.delete(); uc.delete();
    endtask

    task automatic send(input logic c, input logic l);
        int t = 0;
        chip_in = c;
        chip_last = l;
        chip_valid = 1'b1;
        while (!chip_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (chip_ready !== 1'b1) begin
            n_err++;
            $display("FAIL send_timeout ready=%0b required=1", chip_ready);
        end
        @(negedge clk);
        chip_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while ((busy || !chip_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (busy !== 1'b0 || chip_ready !== 1'b1) begin
            n_err++;
            $display("FAIL done_timeout busy=%0b ready=%0b required busy=0 ready=1", busy, chip_ready);
        end
        repeat (5) @(negedge clk);
    endtask

    function automatic int at(input int q[$], input int n);
        return (n < q.size()) ? q[n] : 999;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec += 6;
        if (i_out !== 5'd0) begin n_err++; $display("FAIL rst_i got=%0d exp=0", i_out); end
        if (q_out !== 5'd0) begin n_err++; $display("FAIL rst_q got=%0d exp=0", q_out); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        if (sample_valid !== 1'b0) begin n_err++; $display("FAIL rst_sv got=%0b exp=0", sample_valid); end
        if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_ur got=%0b exp=0", underrun); end
        if (chip_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%0b exp=1", chip_ready); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        repeat (12) @(negedge clk);
        n_vec += 2;
        if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%0b exp=1", busy); end
        if (i_out === 5'd0) begin n_err++; $display("FAIL mid_i got=%0d exp=nonzero", i_out); end
        #3 reset = 1'b1;
        #1;
        n_vec += 4;
        if (i_out !== 5'd0) begin n_err++; $display("FAIL arst_i got=%0d exp=0", i_out); end
        if (q_out !== 5'd0) begin n_err++; $display("FAIL arst_q got=%0d exp=0", q_out); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        if (chip_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got=%0b exp=1", chip_ready); end
        @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (60) @(negedge clk);
        n_vec += 2;
        if (si.size() != 0) begin n_err++; $display("FAIL arst_samples got=%0d exp=0", si.size()); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL arst_idle got=%0b exp=0", busy); end
    endtask

    task automatic test_two_chips();
        clear_logs();
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        wait_done();
        n_vec += 5;
        if (si.size() != 15) begin n_err++; $display("FAIL two_count got=%0d exp=15", si.size()); end
        if (at(sc, 0) - at(xc, 0) != 7) begin n_err++; $display("FAIL two_latency got=%0d exp=7", at(sc, 0) - at(xc, 0)); end
        if (uc.size() != 0) begin n_err++; $display("FAIL two_underrun got=%0d exp=0", uc.size()); end
        if (i_out !== 5'd0 || q_out !== 5'd0) begin n_err++; $display("FAIL two_idle_out got=%0d/%0d exp=0/0", i_out, q_out); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL two_busy got=%0b exp=0", busy); end
        for (int n = 0; n < 15; n++) begin
            int ei, eq;
            ei = (n < 10) ? lut[n] : 0;
            eq = (n < 5) ? 0 : -lut[n - 5];
            n_vec += 2;
            if (at(si, n) != ei) begin n_err++; $display("FAIL two_i[%0d] got=%0d exp=%0d", n, at(si, n), ei); end
            if (at(sq, n) != eq) begin n_err++; $display("FAIL two_q[%0d] got=%0d exp=%0d", n, at(sq, n), eq); end
        end
    endtask

    task automatic test_burst32();
        clear_logs();
        for (int k = 0; k < 32; k++) send(k % 2 == 0, k == 31);
        wait_done();
        n_vec += 2;
        if (si.size() != 165) begin n_err++; $display("FAIL b32_count got=%0d exp=165", si.size()); end
        if (uc.size() != 0) begin n_err++; $display("FAIL b32_underrun got=%0d exp=0", uc.size()); end
        for (int n = 0; n < 165; n++) begin
            int ei, eq;
            ei = (n < 160) ? lut[n % 10] : 0;
            eq = (n < 5) ? 0 : -lut[(n - 5) % 10];
            n_vec += 2;
            if (at(si, n) != ei) begin n_err++; $display("FAIL b32_i[%0d] got=%0d exp=%0d", n, at(si, n), ei); end
            if (at(sq, n) != eq) begin n_err++; $display("FAIL b32_q[%0d] got=%0d exp=%0d", n, at(sq, n), eq); end
        end
        for (int n = 1; n < 165; n++) begin
            n_vec++;
            if (at(sc, n) - at(sc, n - 1) != 5) begin
                n_err++;
                $display("FAIL b32_period[%0d] got=%0d exp=5", n, at(sc, n) - at(sc, n - 1));
            end
        end
    endtask

    task automatic test_starvation();
        clear_logs();
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        wait_done();
        n_vec += 3;
        if (si.size() != 20) begin n_err++; $display("FAIL starve_count got=%0d exp=20", si.size()); end
        if (uc.size() != 1) begin n_err++; $display("FAIL starve_ur_count got=%0d exp=1", uc.size()); end
        if (at(uc, 0) != at(sc, 14)) begin n_err++; $display("FAIL starve_ur_time got=%0d exp=%0d", at(uc, 0), at(sc, 14)); end
        for (int n = 0; n < 20; n++) begin
            int ei, eq;
            ei = lut[n % 10];
            eq = (n >= 5 && n < 15) ? -lut[n - 5] : 0;
            n_vec += 2;
            if (at(si, n) != ei) begin n_err++; $display("FAIL starve_i[%0d] got=%0d exp=%0d", n, at(si, n), ei); end
            if (at(sq, n) != eq) begin n_err++; $display("FAIL starve_q[%0d] got=%0d exp=%0d", n, at(sq, n), eq); end
        end
    endtask

    task automatic test_flush_hold();
        clear_logs();
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        repeat (20) @(negedge clk);
        n_vec += 2;
        if (chip_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%0b exp=0", chip_ready); end
        if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy got=%0b exp=1", busy); end
        send(1'b1, 1'b1);
        wait_done();
        n_vec += 2;
        if (si.size() != 25) begin n_err++; $display("FAIL flush_count got=%0d exp=25", si.size()); end
        if (at(sc, 10) - at(sc, 9) != 6) begin n_err++; $display("FAIL flush_restart got=%0d exp=6", at(sc, 10) - at(sc, 9)); end
        for (int n = 0; n < 25; n++) begin
            int ei, eq, m;
            m = n - 10;
            ei = (n < 10) ? lut[n] : (m < 10) ? -lut[m] : 0;
            eq = (n < 15) ? 0 : lut[m - 5];
            n_vec += 2;
            if (at(si, n) != ei) begin n_err++; $display("FAIL flush_i[%0d] got=%0d exp=%0d", n, at(si, n), ei); end
            if (at(sq, n) != eq) begin n_err++; $display("FAIL flush_q[%0d] got=%0d exp=%0d", n, at(sq, n), eq); end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        for (int k = 0; k < 6; k++) send(k % 2 == 1, k == 5);
        wait_done();
        n_vec += 3;
        if (xc.size() != 6) begin n_err++; $display("FAIL b2b_xfers got=%0d exp=6", xc.size()); end
        if (si.size() != 35) begin n_err++; $display("FAIL b2b_count got=%0d exp=35", si.size()); end
        if (at(xc, 1) - at(xc, 0) != 2) begin n_err++; $display("FAIL b2b_gap1 got=%0d exp=2", at(xc, 1) - at(xc, 0)); end
        for (int k = 2; k < 6; k++) begin
            n_vec++;
            if (at(xc, k) - at(xc, k - 1) != 25) begin
                n_err++;
                $display("FAIL b2b_gap[%0d] got=%0d exp=25", k, at(xc, k) - at(xc, k - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_chips();
        test_burst32();
        test_starvation();
        test_flush_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
